// File: rtl/mult_by_2_arbiter.sv
// Round-robin arbiter in front of a single registered doubling stage.
// One operation is in flight at a time; each result is held until the consumer takes it.
module mult_by_2_arbiter #(
  parameter int WIDTH = 10,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] operand,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   res_valid,
  output logic [WIDTH-1:0]       res_data,
  output logic [ID_W-1:0]        res_id,
  output logic                   res_ovf,
  input  logic                   res_ready
);

  typedef enum logic [1:0] {IDLE, EXEC, RESULT} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   ptr_reg;
  logic [WIDTH-1:0]  cap_reg;
  logic [ID_W-1:0]   cap_id_reg;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic [WIDTH-1:0]  op_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign op_arr[gi] = operand[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_reg) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt        = '0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          gnt        = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
          state_next = EXEC;
        end
      end
      EXEC:    state_next = RESULT;
      RESULT:  if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (rst) gnt = '0;
  end

  assign busy = (state_reg != IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      cap_reg    <= '0;
      cap_id_reg <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= '0;
      res_ovf    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (found) begin
            cap_reg    <= op_arr[winner];
            cap_id_reg <= winner;
            ptr_reg    <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
          end
        end
        EXEC: begin
          res_data  <= {cap_reg[WIDTH-2:0], 1'b0};
          res_ovf   <= cap_reg[WIDTH-1];
          res_id    <= cap_id_reg;
          res_valid <= 1'b1;
        end
        RESULT: begin
          // Data/id/ovf keep their last value after the handshake.
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_by_2_arbiter.sv
// Bench for mult_by_2_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mult_by_2_arbiter;
  localparam int WIDTH = 10;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] operand;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   res_valid;
  logic [WIDTH-1:0]       res_data;
  logic [ID_W-1:0]        res_id;
  logic                   res_ovf;
  logic                   res_ready;

  mult_by_2_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .operand(operand), .gnt(gnt), .busy(busy),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ovf(res_ovf),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = waiting for a request, 1 = operand taken, 2 = result offered.
  int m_phase = 0, m_ptr = 0, m_id = 0, m_data = 0, pend_op = 0, pend_id = 0;
  bit m_valid = 0, m_ovf = 0, m_known = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N_REQ; k++) begin
      if (req[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  function automatic int exp_gnt();
    int w;
    if (rst || m_phase != 0) return 0;
    w = pick();
    return (w < 0) ? 0 : (1 << w);
  endfunction

  task automatic model_step();
    int w;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0; m_ovf = 0; m_known = 1;
    end else if (m_known) begin
      case (m_phase)
        0: begin
          w = pick();
          if (w >= 0) begin
            pend_op = int'(operand[w*WIDTH +: WIDTH]);
            pend_id = w;
            m_ptr   = (w + 1) % N_REQ;
            m_phase = 1;
          end
        end
        1: begin
          m_data  = (pend_op * 2) % (1 << WIDTH);
          m_ovf   = (pend_op >= (1 << (WIDTH - 1)));
          m_id    = pend_id;
          m_valid = 1;
          m_phase = 2;
        end
        default: if (res_ready) begin m_valid = 0; m_phase = 0; end
      endcase
    end
  endtask

  // Compare at the falling edge, advance model at the rising edge, return just after it.
  task automatic tick();
    @(negedge clk);
    if (m_known) begin
      chk("gnt", int'(gnt), exp_gnt());
      chk("busy", int'(busy), int'(m_phase != 0 && !rst));
      chk("res_valid", int'(res_valid), int'(m_valid));
      chk("res_data", int'(res_data), m_data);
      chk("res_id", int'(res_id), m_id);
      chk("res_ovf", int'(res_ovf), int'(m_ovf));
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_op(input int i, input int v);
    operand[i*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic wait_idle();
    int n = 0;
    req = '0;
    res_ready = 1'b1;
    while (m_phase != 0 && n < 10) begin tick(); n++; end
    chk("idle_timeout", int'(m_phase == 0), 1);
  endtask

  task automatic run_op(input int idx, input int v, input int exp_d, input int exp_o);
    wait_idle();
    set_op(idx, v);
    req = N_REQ'(1 << idx);
    #1 chk("single_gnt", int'(gnt), 1 << idx);
    tick();
    req = '0;
    #1 chk("single_busy_exec", int'(busy), 1);
    tick();
    #1;
    chk("single_valid", int'(res_valid), 1);
    chk("single_data", int'(res_data), exp_d);
    chk("single_id", int'(res_id), idx);
    chk("single_ovf", int'(res_ovf), exp_o);
    chk("single_busy_res", int'(busy), 1);
    tick();
  endtask

  int rr_id[5]   = '{0, 1, 2, 3, 0};
  int rr_res[5]  = '{20, 42, 84, 800, 20};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req = '1; operand = '0; res_ready = 1'b1;
    tick();
    for (int c = 0; c < 2; c++) begin
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(res_valid), 0);
      chk("rst_data", int'(res_data), 0);
      chk("rst_id", int'(res_id), 0);
      chk("rst_ovf", int'(res_ovf), 0);
      tick();
    end
    rst = 1'b0;
    #1 chk("first_gnt", int'(gnt), 1);

    run_op(0, 1, 2, 0);
    run_op(2, 987, 950, 1);
    run_op(2, 400, 800, 0);

    // Round-robin from ptr=0 with all requests held.
    wait_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_op(0, 10); set_op(1, 21); set_op(2, 42); set_op(3, 400);
    req = '1;
    for (int k = 0; k < 15; k++) begin
      #1;
      chk("rr_gnt", int'(gnt), (k % 3 == 0) ? (1 << rr_id[k/3]) : 0);
      if (k % 3 == 2) begin
        chk("rr_valid", int'(res_valid), 1);
        chk("rr_data", int'(res_data), rr_res[k/3]);
        chk("rr_id", int'(res_id), rr_id[k/3]);
      end
      tick();
    end

    // Backpressure: requester 1 wins next, result held for 5 cycles.
    res_ready = 1'b0;
    #1 chk("bp_gnt", int'(gnt), 2);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", int'(res_valid), 1);
      chk("bp_data", int'(res_data), 42);
      chk("bp_id", int'(res_id), 1);
      chk("bp_gnt_hold", int'(gnt), 0);
      chk("bp_busy", int'(busy), 1);
      tick();
    end
    res_ready = 1'b1;
    #1 chk("bp_valid_final", int'(res_valid), 1);
    tick();
    #1;
    chk("bp_next_gnt", int'(gnt), 4);
    chk("bp_idle_busy", int'(busy), 0);

    // Reset while the operation is in EXEC.
    wait_idle();
    set_op(0, 42);
    req = 4'b0001;
    tick();
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0110;
    #1;
    chk("midrst_valid", int'(res_valid), 0);
    chk("midrst_gnt", int'(gnt), 2);
    tick();
    req = '0;
    tick();

    // Randomized traffic; requesters hold req/operand until granted.
    for (int c = 0; c < 600; c++) begin
      logic [N_REQ-1:0] g;
      g = gnt;
      for (int i = 0; i < N_REQ; i++) begin
        if (g[i] || !req[i]) begin
          req[i] = ($urandom_range(0, 2) != 0);
          set_op(i, int'($urandom_range(0, (1 << WIDTH) - 1)));
        end
      end
      res_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
